// File: rtl/lsu_mem_adapter.sv
// Load/store adapter in front of memory_unit.
// Word-addressed memory, sub-word stores done as read-modify-write.
module lsu_mem_adapter #(
    parameter int ADDRSIZE = 16,
    parameter int WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [31:0]         req_addr,
    input  logic [WORDSIZE-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [WORDSIZE-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic                mem_wren,
    output logic                mem_rden,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WORDSIZE-1:0] mem_d,
    input  logic [WORDSIZE-1:0] mem_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [1:0]          lane_q, lane_d;
    logic [ADDRSIZE-1:0] maddr_q, maddr_d;
    logic [WORDSIZE-1:0] mdata_q, mdata_d;
    logic                wren_q, wren_d;
    logic                rden_q, rden_d;
    logic                rvalid_q, rvalid_d;
    logic [WORDSIZE-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                req_bad;
    logic [7:0]          q_byte;
    logic [15:0]         q_half;
    logic [WORDSIZE-1:0] load_val;
    logic [WORDSIZE-1:0] merged;

    // Upper byte-address bits alias away by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDRSIZE+2];

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rvalid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_wren  = wren_q;
    assign mem_rden  = rden_q;
    assign mem_addr  = maddr_q;
    assign mem_d     = mdata_q;

    // Illegal size or an access not aligned to its own size.
    always_comb begin
        req_bad = 1'b0;
        unique case (req_size)
            SZ_B: req_bad = 1'b0;
            SZ_H: req_bad = req_addr[0];
            SZ_W: req_bad = (req_addr[1:0] != 2'b00);
            SZ_X: req_bad = 1'b1;
            default: req_bad = 1'b1;
        endcase
    end

    // Lane extraction and extension of the returned word for loads.
    always_comb begin
        q_byte   = 8'h00;
        q_half   = lane_q[1] ? mem_q[31:16] : mem_q[15:0];
        load_val = mem_q;
        unique case (lane_q)
            2'd0: q_byte = mem_q[7:0];
            2'd1: q_byte = mem_q[15:8];
            2'd2: q_byte = mem_q[23:16];
            2'd3: q_byte = mem_q[31:24];
            default: q_byte = 8'h00;
        endcase
        unique case (size_q)
            SZ_B: load_val = uns_q ? {24'h0, q_byte}
                                   : {{24{q_byte[7]}}, q_byte};
            SZ_H: load_val = uns_q ? {16'h0, q_half}
                                   : {{16{q_half[15]}}, q_half};
            default: load_val = mem_q;
        endcase
    end

    // Splice the addressed byte/half of the store data into the old word.
    always_comb begin
        merged = mem_q;
        if (size_q == SZ_B) begin
            merged[{lane_q, 3'b000} +: 8] = mdata_q[7:0];
        end else if (size_q == SZ_H) begin
            if (lane_q[1]) merged[31:16] = mdata_q[15:0];
            else           merged[15:0]  = mdata_q[15:0];
        end
    end

    // Next-state and next-output logic of the request FSM.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        lane_d   = lane_q;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    lane_d  = req_addr[1:0];
                    maddr_d = req_addr[ADDRSIZE+1:2];
                    mdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (req_bad) begin
                        err_d    = 1'b1;
                        rvalid_d = 1'b1;
                        state_d  = S_RESP;
                    end else if (req_we && req_size == SZ_W) begin
                        wren_d  = 1'b1;
                        state_d = S_WR;
                    end else begin
                        rden_d  = 1'b1;
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                if (we_q) begin
                    mdata_d = merged;
                    wren_d  = 1'b1;
                    state_d = S_WR;
                end else begin
                    rdata_d  = load_val;
                    rvalid_d = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_WR: begin
                rvalid_d = 1'b1;
                state_d  = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            lane_q   <= 2'b00;
            maddr_q  <= '0;
            mdata_q  <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            lane_q   <= lane_d;
            maddr_q  <= maddr_d;
            mdata_q  <= mdata_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed bench for lsu_mem_adapter with a behavioural memory_unit.
// Second instance uses ADDRSIZE=4 to exercise address aliasing.
module tb_lsu_mem_adapter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_a = 1'b0;
    logic        req_valid_b = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        a_ready, a_rsp_valid, a_rsp_err, a_wren, a_rden;
    logic [31:0] a_rsp_rdata, a_d, a_q;
    logic [15:0] a_addr;
    logic        b_ready, b_rsp_valid, b_rsp_err, b_wren, b_rden;
    logic [31:0] b_rsp_rdata, b_d, b_q;
    logic [3:0]  b_addr;

    logic [31:0] mem_a [0:65535];
    logic [31:0] mem_b [0:15];

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt = 0, rd_cnt = 0, rsp_cnt = 0;
    logic [31:0] last_wr_d = '0;
    logic [15:0] last_wr_addr = '0;
    logic [3:0]  b_wr_addr = '0, b_rd_addr = '0;

    always #5 clk = ~clk;

    lsu_mem_adapter #(.ADDRSIZE(16), .WORDSIZE(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(a_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err),
        .mem_wren(a_wren), .mem_rden(a_rden),
        .mem_addr(a_addr), .mem_d(a_d), .mem_q(a_q)
    );

    lsu_mem_adapter #(.ADDRSIZE(4), .WORDSIZE(32)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(b_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err),
        .mem_wren(b_wren), .mem_rden(b_rden),
        .mem_addr(b_addr), .mem_d(b_d), .mem_q(b_q)
    );

    // Behavioural memory_unit: synchronous write, registered read.
    always @(posedge clk) begin
        if (a_wren) mem_a[a_addr] <= a_d;
        if (a_rden) a_q <= mem_a[a_addr];
        if (b_wren) mem_b[b_addr] <= b_d;
        if (b_rden) b_q <= mem_b[b_addr];
    end

    // Port activity monitor for instance a, aliasing addresses for b.
    always @(posedge clk) begin
        if (a_wren) begin
            wr_cnt <= wr_cnt + 1;
            last_wr_d <= a_d;
            last_wr_addr <= a_addr;
        end
        if (a_rden) rd_cnt <= rd_cnt + 1;
        if (a_wren && a_rden) rd_cnt <= rd_cnt + 1000;
        if (a_rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (b_wren) b_wr_addr <= b_addr;
        if (b_rden) b_rd_addr <= b_addr;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        wr_cnt = 0;
        rd_cnt = 0;
        rsp_cnt = 0;
    endtask

    task automatic do_req(input bit sel, input bit we,
                          input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat);
        bit got;
        @(negedge clk);
        chk("ready", sel ? b_ready : a_ready, 1);
        req_we = we;
        req_size = size;
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wdata;
        if (sel) req_valid_b = 1'b1;
        else     req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        got = 1'b0;
        lat = 0;
        rdata = '0;
        err = 1'b0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (sel ? b_rsp_valid : a_rsp_valid) begin
                got = 1'b1;
                lat = i;
                rdata = sel ? b_rsp_rdata : a_rsp_rdata;
                err = sel ? b_rsp_err : a_rsp_err;
            end
        end
        if (!got) chk("rsp_timeout", 0, 1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt;

    initial begin
        #12;
        chk("rst_ready", a_ready, 1);
        chk("rst_rsp_valid", a_rsp_valid, 0);
        chk("rst_wren", a_wren, 0);
        chk("rst_rden", a_rden, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_d", a_d, 0);
        chk("rst_rdata", a_rsp_rdata, 0);
        chk("rst_err", a_rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        clr_mon();
        do_req(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, er, lt);
        chk("sw_lat", lt, 2);
        chk("sw_err", er, 0);
        chk("sw_rdata", rd, 0);
        chk("sw_wr_cnt", wr_cnt, 1);
        chk("sw_rd_cnt", rd_cnt, 0);
        chk("sw_wr_addr", last_wr_addr, 16'd4);
        chk("sw_wr_d", last_wr_d, 32'hDEADBEEF);
        do_req(0, 0, 2'b10, 0, 32'h10, 0, rd, er, lt);
        chk("lw_data", rd, 32'hDEADBEEF);
        chk("lw_lat", lt, 3);
        chk("lw_err", er, 0);

        do_req(0, 1, 2'b10, 0, 32'h20, 32'h11223344, rd, er, lt);
        clr_mon();
        do_req(0, 1, 2'b00, 0, 32'h21, 32'h123456AA, rd, er, lt);
        chk("sb_lat", lt, 4);
        chk("sb_rd_cnt", rd_cnt, 1);
        chk("sb_wr_cnt", wr_cnt, 1);
        chk("sb_wr_addr", last_wr_addr, 16'd8);
        chk("sb_merge", last_wr_d, 32'h1122AA44);
        do_req(0, 0, 2'b10, 0, 32'h20, 0, rd, er, lt);
        chk("sb_readback", rd, 32'h1122AA44);
        do_req(0, 1, 2'b01, 1, 32'h22, 32'h5555BEEF, rd, er, lt);
        chk("sh_lat", lt, 4);
        do_req(0, 0, 2'b10, 0, 32'h20, 0, rd, er, lt);
        chk("sh_readback", rd, 32'hBEEFAA44);

        do_req(0, 1, 2'b10, 0, 32'h30, 32'h80F07F01, rd, er, lt);
        do_req(0, 0, 2'b00, 0, 32'h32, 0, rd, er, lt);
        chk("lb_32", rd, 32'hFFFFFFF0);
        do_req(0, 0, 2'b00, 1, 32'h32, 0, rd, er, lt);
        chk("lbu_32", rd, 32'h000000F0);
        do_req(0, 0, 2'b01, 0, 32'h32, 0, rd, er, lt);
        chk("lh_32", rd, 32'hFFFF80F0);
        do_req(0, 0, 2'b01, 1, 32'h30, 0, rd, er, lt);
        chk("lhu_30", rd, 32'h00007F01);
        do_req(0, 0, 2'b00, 0, 32'h31, 0, rd, er, lt);
        chk("lb_31", rd, 32'h0000007F);
        do_req(0, 0, 2'b00, 0, 32'h33, 0, rd, er, lt);
        chk("lb_33", rd, 32'hFFFFFF80);
        do_req(0, 0, 2'b00, 1, 32'h30, 0, rd, er, lt);
        chk("lbu_30", rd, 32'h00000001);
        do_req(0, 0, 2'b10, 1, 32'h30, 0, rd, er, lt);
        chk("lw_uns_ignored", rd, 32'h80F07F01);

        clr_mon();
        do_req(0, 0, 2'b10, 0, 32'h12, 0, rd, er, lt);
        chk("lw_mis_err", er, 1);
        chk("lw_mis_lat", lt, 1);
        chk("lw_mis_rdata", rd, 0);
        do_req(0, 1, 2'b01, 0, 32'h13, 32'hFFFF, rd, er, lt);
        chk("sh_mis_err", er, 1);
        chk("sh_mis_lat", lt, 1);
        do_req(0, 0, 2'b11, 0, 32'h10, 0, rd, er, lt);
        chk("sz11_err", er, 1);
        chk("sz11_rdata", rd, 0);
        chk("err_no_wr", wr_cnt, 0);
        chk("err_no_rd", rd_cnt, 0);
        do_req(0, 0, 2'b10, 0, 32'h10, 0, rd, er, lt);
        chk("err_cleared", er, 0);
        chk("after_err_data", rd, 32'hDEADBEEF);

        do_req(0, 1, 2'b10, 0, 32'h40, 32'h01234567, rd, er, lt);
        @(negedge clk);
        req_we = 1'b1;
        req_size = 2'b01;
        req_unsigned = 1'b0;
        req_addr = 32'h40;
        req_wdata = 32'h0000BEEF;
        req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        clr_mon();
        @(negedge clk);
        chk("abort_rd_phase", a_rden, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_wren", a_wren, 0);
        chk("abort_ready", a_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_wr", wr_cnt, 0);
        chk("abort_no_rsp", rsp_cnt, 0);
        do_req(0, 0, 2'b10, 0, 32'h40, 0, rd, er, lt);
        chk("abort_readback", rd, 32'h01234567);

        do_req(1, 1, 2'b10, 0, 32'h44, 32'h5, rd, er, lt);
        chk("alias_sw_err", er, 0);
        chk("alias_wr_addr", b_wr_addr, 4'd1);
        do_req(1, 0, 2'b10, 0, 32'h04, 0, rd, er, lt);
        chk("alias_lw", rd, 32'h5);
        chk("alias_rd_addr", b_rd_addr, 4'd1);
        chk("alias_err", er, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
